// File: rtl/pipeline_pkg.sv
// Shared types for the writeback stage: queued-instruction entry and FSM state.
package pipeline_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     result;
  } wb_entry_t;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head (dout valid whenever not empty).
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: in-order retire of queued results, pairing loads with returned data.
// Optional WB_HAZARD_QUERY_EN adds query_rs/query_hit for decode stall checks.
//   state     | meaning
//   RUN       | head absent, non-load, or load with data queued
//   WAIT_LOAD | head is a load whose data beat has not arrived
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DW-1:0]         in_alu_result,
  input  logic                  mem_rdata_valid,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  r_write,
  output logic [REG_ADDR_W-1:0] rd_write,
  output logic [DW-1:0]         data_out,
  output logic                  wait_load,
  output logic                  err
`ifdef WB_HAZARD_QUERY_EN
  ,
  input  logic [REG_ADDR_W-1:0] query_rs,
  output logic                  query_hit
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t     in_entry;
  wb_entry_t     head;
  logic [DW-1:0] ld_head;
  logic          iq_push, iq_full, iq_empty;
  logic          ldq_push, ldq_full, ldq_empty;
  logic          retire, beat_err;
  logic [CW-1:0] iq_count, ldq_count, alu_cnt, load_cnt;
  wb_state_t     state;

  assign in_entry = '{reg_write:  in_reg_write,
                      mem_to_reg: in_mem_to_reg,
                      rd:         in_rd,
                      result:     DATA_W'(in_alu_result)};

  assign in_ready = !iq_full;
  assign iq_push  = in_valid && in_ready && (in_reg_write || in_mem_to_reg);
  assign retire   = !iq_empty && (!head.mem_to_reg || !ldq_empty);

  // A beat is only legal if a queued load is still waiting for it.
  assign load_cnt = iq_count - alu_cnt;
  assign ldq_push = mem_rdata_valid && !ldq_full && (ldq_count < load_cnt);
  assign beat_err = mem_rdata_valid && !ldq_push;

  assign wait_load = (state == WAIT_LOAD);

  sync_fifo #(.W($bits(wb_entry_t)), .DEPTH(DEPTH)) u_iq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (iq_push),
    .din   (in_entry),
    .pop   (retire),
    .dout  (head),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_ldq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ldq_push),
    .din   (mem_rdata),
    .pop   (retire && head.mem_to_reg),
    .dout  (ld_head),
    .full  (ldq_full),
    .empty (ldq_empty),
    .count (ldq_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt <= '0;
    end else begin
      alu_cnt <= alu_cnt + CW'(iq_push && !in_mem_to_reg) - CW'(retire && !head.mem_to_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      r_write  <= 1'b0;
      rd_write <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      r_write <= retire && head.reg_write;
      if (retire) begin
        rd_write <= head.rd;
        data_out <= head.mem_to_reg ? ld_head : DW'(head.result);
      end
      if (beat_err) err <= 1'b1;
      case (state)
        RUN:       if (!iq_empty && head.mem_to_reg && ldq_empty) state <= WAIT_LOAD;
        WAIT_LOAD: if (!ldq_empty) state <= RUN;
        default:   state <= RUN;
      endcase
    end
  end

`ifdef WB_HAZARD_QUERY_EN
  // Per-register count of queued writers; stays set through the retire cycle.
  logic [CW-1:0] pend [2**REG_ADDR_W];

  assign query_hit = (pend[query_rs] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < 2**REG_ADDR_W; i++) begin
        pend[i] <= pend[i]
                   + CW'(iq_push && in_reg_write && (in_rd == REG_ADDR_W'(i)))
                   - CW'(retire && head.reg_write && (head.rd == REG_ADDR_W'(i)));
      end
    end
  end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic [3:0]  in_rd = '0;
  logic [31:0] in_alu_result = '0;
  logic        mem_rdata_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        r_write;
  logic [3:0]  rd_write;
  logic [31:0] data_out;
  logic        wait_load;
  logic        err;
`ifdef WB_HAZARD_QUERY_EN
  logic [3:0]  query_rs = '0;
  logic        query_hit;
`endif

  int checks = 0;
  int errors = 0;

  writeback_stage #(.DEPTH(4), .DW(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_reg_write    (in_reg_write),
    .in_mem_to_reg   (in_mem_to_reg),
    .in_rd           (in_rd),
    .in_alu_result   (in_alu_result),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .r_write         (r_write),
    .rd_write        (rd_write),
    .data_out        (data_out),
    .wait_load       (wait_load),
    .err             (err)
`ifdef WB_HAZARD_QUERY_EN
    ,
    .query_rs        (query_rs),
    .query_hit       (query_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic m2r, input logic [3:0] rd, input logic [31:0] alu);
    chk("send_ready", in_ready, 1);
    in_valid = 1'b1; in_reg_write = rw; in_mem_to_reg = m2r; in_rd = rd; in_alu_result = alu;
    tick;
    in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    mem_rdata_valid = 1'b1; mem_rdata = d;
    tick;
    mem_rdata_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_r_write", r_write, 0);
    chk("rst_rd_write", rd_write, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_wait_load", wait_load, 0);
    chk("rst_err", err, 0);
    tick; tick;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // ALU op: pulse only in cycle 2
    send(1, 0, 4'd5, 32'h0000_00AA);
    chk("alu_c1_r_write", r_write, 0);
    tick;
    chk("alu_c2_r_write", r_write, 1);
    chk("alu_c2_rd", rd_write, 5);
    chk("alu_c2_data", data_out, 32'hAA);
    tick;
    chk("alu_c3_r_write", r_write, 0);
    chk("alu_c3_data_hold", data_out, 32'hAA);

    // Load with data arriving in cycle 5
    send(1, 1, 4'd3, 32'h0);
    chk("ld_c1_wait", wait_load, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ld_wait", wait_load, 1);
      chk("ld_wait_r_write", r_write, 0);
    end
    tick;
    beat(32'hDEAD_BEEF);
    chk("ld_m1_wait", wait_load, 1);
    chk("ld_m1_r_write", r_write, 0);
    tick;
    chk("ld_m2_r_write", r_write, 1);
    chk("ld_m2_rd", rd_write, 3);
    chk("ld_m2_data", data_out, 32'hDEAD_BEEF);
    chk("ld_m2_wait", wait_load, 0);
    chk("ld_err", err, 0);
    tick;

    // Ordering: late load data must not let the ALU op pass
    send(1, 1, 4'd1, 32'h0);
    send(1, 0, 4'd2, 32'h22);
    chk("ord_c2_r_write", r_write, 0);
    chk("ord_c2_wait", wait_load, 1);
    tick;
    chk("ord_c3_r_write", r_write, 0);
    beat(32'h11);
    chk("ord_c4_r_write", r_write, 0);
    tick;
    chk("ord_first_r_write", r_write, 1);
    chk("ord_first_rd", rd_write, 1);
    chk("ord_first_data", data_out, 32'h11);
    tick;
    chk("ord_second_r_write", r_write, 1);
    chk("ord_second_rd", rd_write, 2);
    chk("ord_second_data", data_out, 32'h22);
    tick;
    chk("ord_idle_r_write", r_write, 0);

    // Fill with four loads, hold a fifth, then drain
    for (int i = 0; i < 4; i++) send(1, 1, 4'(8 + i), 32'h0);
    chk("fill_not_ready", in_ready, 0);
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b0; in_rd = 4'd12; in_alu_result = 32'hCC;
    tick;
    chk("fill_held", in_ready, 0);
    chk("fill_held_r_write", r_write, 0);
    for (int i = 0; i < 4; i++) begin
      mem_rdata_valid = 1'b1; mem_rdata = 32'(32'h100 + i);
      tick;
      if (i == 0) begin
        chk("fill_b1_r_write", r_write, 0);
      end else begin
        chk("fill_r_write", r_write, 1);
        chk("fill_rd", rd_write, 32'(8 + i - 1));
        chk("fill_data", data_out, 32'(32'h100 + i - 1));
      end
      if (i == 1) chk("fill_ready_back", in_ready, 1);
      if (i == 2) begin
        in_valid = 1'b0; in_reg_write = 1'b0;
      end
    end
    mem_rdata_valid = 1'b0;
    tick;
    chk("fill_last_r_write", r_write, 1);
    chk("fill_last_rd", rd_write, 11);
    chk("fill_last_data", data_out, 32'h103);
    tick;
    chk("fill_fifth_r_write", r_write, 1);
    chk("fill_fifth_rd", rd_write, 12);
    chk("fill_fifth_data", data_out, 32'hCC);
    tick;
    chk("fill_idle_r_write", r_write, 0);
    chk("fill_ready_end", in_ready, 1);
    chk("fill_err", err, 0);

    // Spurious beat with nothing outstanding
    beat(32'h55);
    chk("err_set", err, 1);
    tick; tick;
    chk("err_sticky", err, 1);
    chk("err_no_write", r_write, 0);

`ifdef WB_HAZARD_QUERY_EN
    query_rs = 4'd7;
    send(1, 0, 4'd7, 32'h77);
    chk("hz_hit", query_hit, 1);
    tick;
    chk("hz_after_retire", query_hit, 0);
    chk("hz_retire_rd", rd_write, 7);
    send(0, 1, 4'd7, 32'h0);
    chk("hz_no_rw", query_hit, 0);
    beat(32'h5);
    chk("hz_no_rw_wait", query_hit, 0);
    tick;
    chk("hz_no_rw_r_write", r_write, 0);
    tick;
`endif

    // Reset mid-load discards pending entries
    send(1, 1, 4'd4, 32'h0);
    send(1, 0, 4'd6, 32'h66);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_r_write", r_write, 0);
    chk("mid_rst_rd", rd_write, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_wait", wait_load, 0);
    chk("mid_rst_err", err, 0);
    tick;
    rst_n = 1'b1;
    chk("mid_rst_ready", in_ready, 1);
    beat(32'h99);
    chk("mid_rst_q_empty_err", err, 1);
    tick;
    chk("mid_rst_no_write", r_write, 0);

    // rd = 0 is an ordinary destination
    send(1, 0, 4'd0, 32'h1234);
    tick;
    chk("rd0_r_write", r_write, 1);
    chk("rd0_rd", rd_write, 0);
    chk("rd0_data", data_out, 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. Buffers completed instructions from the memory stage in program order.
- Pairs each load with its returned memory data and drives the register-file write port that feeds the decode stage: r_write, rd_write, data_out.
- Pairs with the decode stage: this block is the sole writer of the decode register file's write port.

Parameters:
- DEPTH, 4, number of entries in the instruction queue and in the load-data queue (power of two, minimum 2).
- DW, 32, data width of results and register write data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; in_ready = queue not full.
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  instruction is a load; result comes from mem_rdata.
- in_rd  in  4  destination register.
- in_alu_result  in  DW  non-load result.
- mem_rdata_valid  in  1  one load-data beat this cycle; no backpressure.
- mem_rdata  in  DW  load data, returned in program order.
- r_write  out  1  register-file write enable (single-cycle pulse per retire).
- rd_write  out  4  register-file write address.
- data_out  out  DW  register-file write data.
- wait_load  out  1  high while the head entry is a load with no data yet.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst_n low):
  - r_write, rd_write, data_out, wait_load, err are 0.
  - Both queues empty; FSM in RUN.
  - in_ready is high once rst_n deasserts.
- Enqueue:
  - Occurs on in_valid && in_ready.
  - Stores {reg_write, mem_to_reg, rd, alu_result}.
  - Instructions with in_reg_write=0 and in_mem_to_reg=0 are accepted but not enqueued.
  - A load is always enqueued, even with reg_write=0, so that it consumes its data beat.
- Load-data queue:
  - mem_rdata_valid pushes mem_rdata.
  - Push when the load-data queue is full: beat dropped, err set.
  - Push when the number of beats would exceed the number of outstanding loads in the instruction queue: beat dropped, err set.
- Retire:
  - At most one per cycle. Head retires when it is a non-load, or a load with the load-data queue non-empty.
  - A retiring load pops both queues.
  - The next cycle drives r_write = head.reg_write, rd_write = head.rd, data_out = load ? load-data head : alu_result.
  - Cycles with no retire drive r_write = 0; rd_write and data_out hold their last values.
- Latency:
  - Non-load accepted in cycle N retires at the end of N+1; r_write is high in N+2.
  - Load with data pushed in cycle M retires at the end of M+1 at the earliest; r_write is high in M+2.
  - No same-cycle pass-through from input to output.
- FSM:
  - RUN -> WAIT_LOAD when the head is a load and the load-data queue is empty.
  - WAIT_LOAD -> RUN in the cycle data is present; retire is that cycle.
  - wait_load = (state == WAIT_LOAD).
- Boundaries:
  - Full queue: in_ready low; no enqueue even if a retire occurs the same cycle.
  - Enqueue into an empty queue: not retired in the same cycle.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - rd = 0 is not special-cased.
  - err is cleared only by reset.
  - Reset mid-load discards all pending entries and data.

Optional Feature:
- Macro: WB_HAZARD_QUERY_EN.
- When defined, adds two ports:
  - query_rs  in  4
  - query_hit  out  1
- query_hit is combinational: 1 if any valid queued entry with reg_write=1 has rd == query_rs, including the entry being retired this cycle. Decode uses it to stall.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package pipeline_pkg holds:
  - REG_ADDR_W = 4, DATA_W = 32.
  - wb_entry_t = {reg_write, mem_to_reg, rd, result}.
  - FSM state enum {RUN, WAIT_LOAD}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count), instantiated twice for the instruction queue and the load-data queue.

Test Plan:
- ALU op: in_rd = 5, alu = 0x0000_00AA, reg_write = 1 accepted at cycle 0 -> r_write = 1, rd_write = 5, data_out = 0xAA at cycle 2 only.
- Load: rd = 3, mem_to_reg = 1, data 0xDEAD_BEEF arrives 5 cycles later -> wait_load high until data; r_write with rd_write = 3, data_out = 0xDEADBEEF two cycles after the beat.
- Ordering: load(rd = 1) then ALU(rd = 2, 0x22); data 0x11 arrives late -> writes rd = 1 / 0x11, then rd = 2 / 0x22, never reordered.
- Fill: DEPTH = 4 loads with no data -> in_ready low after 4th accept; 5th held. Four beats arrive -> four consecutive r_write pulses and in_ready returns.
- Errors: mem_rdata_valid with no outstanding load -> err = 1 and stays 1. Assert rst_n = 0 mid-stream -> all outputs 0 immediately and queues empty.
- With WB_HAZARD_QUERY_EN: enqueue ALU to rd = 7, query_rs = 7 -> query_hit = 1. After the retire cycle, query_hit = 0. Entry with reg_write = 0 never hits.
